regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (WriteEn/WriteDir/WriteData) between two writeback requesters: A (ALU) and B (load unit).
- Each requester has its own small in-order FIFO. A round-robin scheduler drains the FIFOs into a registered write port.
- A pending-register bitmap lets the issue stage stall on RAW hazards until the write has reached the register file.

---
 rtl/regfile_wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the single register-file write port.
// Per-requester FIFOs, round-robin drain, and a pending-register bitmap.

module regfile_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [4:0]      push_dir,
    input  logic [XLEN-1:0] push_data,
    input  logic            pop,
    output logic            ready,
    output logic            empty,
    output logic [4:0]      head_dir,
    output logic [XLEN-1:0] head_data,
    output logic [31:0]     held
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]      dir_q  [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic [AW:0]     count;
    logic [AW-1:0]   rel;

    assign count     = wptr - rptr;
    assign ready     = count != FULL;
    assign empty     = count == '0;
    assign head_dir  = dir_q[rptr[AW-1:0]];
    assign head_data = data_q[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + ONE;
            if (pop)  rptr <= rptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dir_q[wptr[AW-1:0]]  <= push_dir;
            data_q[wptr[AW-1:0]] <= push_data;
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        held = '0;
        rel  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = AW'(i) - rptr[AW-1:0];
            if ({1'b0, rel} < count) held[dir_q[i]] = 1'b1;
        end
    end

endmodule

module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_dir,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_dir,
    input  logic [XLEN-1:0] b_data,
    output logic            rf_we,
    output logic [4:0]      rf_dir,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     pending
);

    logic            a_push;
    logic            b_push;
    logic            a_empty;
    logic            b_empty;
    logic [4:0]      a_head_dir;
    logic [4:0]      b_head_dir;
    logic [XLEN-1:0] a_head_data;
    logic [XLEN-1:0] b_head_data;
    logic [31:0]     a_held;
    logic [31:0]     b_held;
    logic            grant_a;
    logic            grant_b;
    logic            last_b;

    // x0 writes complete the handshake but never enter a FIFO.
    assign a_push = a_valid & a_ready & (a_dir != 5'd0);
    assign b_push = b_valid & b_ready & (b_dir != 5'd0);

    regfile_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (a_push),
        .push_dir  (a_dir),
        .push_data (a_data),
        .pop       (grant_a),
        .ready     (a_ready),
        .empty     (a_empty),
        .head_dir  (a_head_dir),
        .head_data (a_head_data),
        .held      (a_held)
    );

    regfile_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push),
        .push_dir  (b_dir),
        .push_data (b_data),
        .pop       (grant_b),
        .ready     (b_ready),
        .empty     (b_empty),
        .head_dir  (b_head_dir),
        .head_data (b_head_data),
        .held      (b_held)
    );

    assign grant_a = !a_empty && (b_empty || last_b);
    assign grant_b = !b_empty && (a_empty || !last_b);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we    <= 1'b0;
            rf_dir   <= '0;
            rf_wdata <= '0;
            last_b   <= 1'b1;
        end else begin
            rf_we <= grant_a | grant_b;
            if (grant_a) begin
                rf_dir   <= a_head_dir;
                rf_wdata <= a_head_data;
                last_b   <= 1'b0;
            end else if (grant_b) begin
                rf_dir   <= b_head_dir;
                rf_wdata <= b_head_data;
                last_b   <= 1'b1;
            end
        end
    end

    always_comb begin
        pending = a_held | b_held;
        if (rf_we) pending[rf_dir] = 1'b1;
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: cycle table plus scoreboarded streams.

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_dir = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_dir = '0;
    logic [31:0] b_data = '0;
    logic        rf_we;
    logic [4:0]  rf_dir;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_dir    (a_dir),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_dir    (b_dir),
        .b_data   (b_data),
        .rf_we    (rf_we),
        .rf_dir   (rf_dir),
        .rf_wdata (rf_wdata),
        .pending  (pending)
    );

    typedef struct {
        logic        rst_before;
        logic        av;
        logic [4:0]  ad;
        logic [31:0] adata;
        logic        bv;
        logic [4:0]  bd;
        logic [31:0] bdata;
        logic        ar;
        logic        br;
        logic        we;
        logic [4:0]  dir;
        logic [31:0] wd;
        logic [31:0] pend;
    } vec_t;

    typedef struct {
        logic [4:0]  dir;
        logic [31:0] data;
    } item_t;

    vec_t  vecs [13];
    item_t src_a [$];
    item_t src_b [$];
    item_t exp_a [$];
    item_t exp_b [$];
    logic  rdy_hist [$];
    bit    mon_on = 1'b0;
    int    wr_count = 0;

    // Every register-file write during a stream must match the head of one
    // requester's expected queue, which enforces per-requester order.
    always @(negedge clk) begin
        if (mon_on && rf_we) begin
            tests++;
            wr_count++;
            if (exp_a.size() > 0 && exp_a[0].dir == rf_dir &&
                exp_a[0].data == rf_wdata)
                void'(exp_a.pop_front());
            else if (exp_b.size() > 0 && exp_b[0].dir == rf_dir &&
                     exp_b[0].data == rf_wdata)
                void'(exp_b.pop_front());
            else begin
                fails++;
                $display("FAIL rf_write: got dir=%0d data=%h, not at head of A or B queue",
                         rf_dir, rf_wdata);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_stream();
        int ai  = 0;
        int bi  = 0;
        int cyc = 0;
        bit a_acc;
        bit b_acc;
        rdy_hist.delete();
        while ((ai < src_a.size() || bi < src_b.size()) && cyc < 200) begin
            @(negedge clk);
            a_valid = ai < src_a.size();
            b_valid = bi < src_b.size();
            if (a_valid) begin
                a_dir  = src_a[ai].dir;
                a_data = src_a[ai].data;
            end
            if (b_valid) begin
                b_dir  = src_b[bi].dir;
                b_data = src_b[bi].data;
            end
            rdy_hist.push_back(b_ready);
            a_acc = a_valid && a_ready;
            b_acc = b_valid && b_ready;
            @(posedge clk);
            if (a_acc) begin
                exp_a.push_back(src_a[ai]);
                ai++;
            end
            if (b_acc) begin
                exp_b.push_back(src_b[bi]);
                bi++;
            end
            cyc++;
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("stream_accept_all", 64'(ai + bi),
              64'(src_a.size() + src_b.size()));
        cyc = 0;
        while ((exp_a.size() > 0 || exp_b.size() > 0) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("stream_drain", 64'(exp_a.size() + exp_b.size()), 64'd0);
    endtask

    initial begin
        // rst av ad adata bv bd bdata | ar br we dir wd pend
        vecs[0]  = '{1, 1, 5, 32'h11, 0, 0, 0,      1, 1, 0, 0, 0,      32'h0};
        vecs[1]  = '{0, 0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 0,      32'h20};
        vecs[2]  = '{0, 0, 0, 0,      0, 0, 0,      1, 1, 1, 5, 32'h11, 32'h20};
        vecs[3]  = '{0, 0, 0, 0,      0, 0, 0,      1, 1, 0, 5, 32'h11, 32'h0};
        vecs[4]  = '{1, 1, 1, 32'hA1, 1, 3, 32'hB3, 1, 1, 0, 0, 0,      32'h0};
        vecs[5]  = '{0, 1, 2, 32'hA2, 1, 4, 32'hB4, 1, 1, 0, 0, 0,      32'h0A};
        vecs[6]  = '{0, 0, 0, 0,      0, 0, 0,      1, 0, 1, 1, 32'hA1, 32'h1E};
        vecs[7]  = '{0, 0, 0, 0,      0, 0, 0,      1, 1, 1, 3, 32'hB3, 32'h1C};
        vecs[8]  = '{0, 0, 0, 0,      0, 0, 0,      1, 1, 1, 2, 32'hA2, 32'h14};
        vecs[9]  = '{0, 0, 0, 0,      0, 0, 0,      1, 1, 1, 4, 32'hB4, 32'h10};
        vecs[10] = '{0, 1, 0, 32'hFFFF, 0, 0, 0,    1, 1, 0, 4, 32'hB4, 32'h0};
        vecs[11] = '{0, 0, 0, 0,      0, 0, 0,      1, 1, 0, 4, 32'hB4, 32'h0};
        vecs[12] = '{0, 0, 0, 0,      0, 0, 0,      1, 1, 0, 4, 32'hB4, 32'h0};

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rst_before) do_reset();
            @(negedge clk);
            a_valid = vecs[i].av;
            a_dir   = vecs[i].ad;
            a_data  = vecs[i].adata;
            b_valid = vecs[i].bv;
            b_dir   = vecs[i].bd;
            b_data  = vecs[i].bdata;
            tests++;
            if (a_ready !== vecs[i].ar || b_ready !== vecs[i].br ||
                rf_we !== vecs[i].we || rf_dir !== vecs[i].dir ||
                rf_wdata !== vecs[i].wd || pending !== vecs[i].pend) begin
                fails++;
                $display("FAIL row%0d: got rdy=%b%b we=%b dir=%0d wd=%h pend=%h expected rdy=%b%b we=%b dir=%0d wd=%h pend=%h",
                         i, a_ready, b_ready, rf_we, rf_dir, rf_wdata, pending,
                         vecs[i].ar, vecs[i].br, vecs[i].we, vecs[i].dir,
                         vecs[i].wd, vecs[i].pend);
            end
        end

        // Backpressure: A streams while B pushes three back-to-back.
        do_reset();
        src_a.delete();
        src_b.delete();
        for (int i = 0; i < 6; i++) src_a.push_back('{5'(8 + i), 32'hA0 + i});
        for (int i = 0; i < 3; i++) src_b.push_back('{5'(16 + i), 32'hB0 + i});
        wr_count = 0;
        mon_on   = 1'b1;
        run_stream();
        mon_on = 1'b0;
        check("bp_writes", 64'(wr_count), 64'd9);
        check("bp_b_ready_t1", 64'(rdy_hist[1]), 64'd1);
        check("bp_b_ready_t2", 64'(rdy_hist[2]), 64'd0);
        check("bp_b_ready_t3", 64'(rdy_hist[3]), 64'd1);

        // Reset mid-stream: both FIFOs loaded, then reset for one edge.
        do_reset();
        @(negedge clk);
        a_valid = 1'b1; a_dir = 5'd1; a_data = 32'hDEAD0001;
        b_valid = 1'b1; b_dir = 5'd2; b_data = 32'hDEAD0002;
        @(negedge clk);
        a_dir = 5'd3; a_data = 32'hDEAD0003;
        b_dir = 5'd4; b_data = 32'hDEAD0004;
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("mid_pending_before", 64'(pending != 32'h0), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_we", 64'(rf_we), 64'd0);
        check("mid_rst_pending", 64'(pending), 64'd0);
        check("mid_rst_ready", 64'({a_ready, b_ready}), 64'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_no_stale", 64'({rf_we, rf_wdata}), 64'd0);
        end

        // Wrap-around: twenty A writes through a two-entry FIFO.
        do_reset();
        src_a.delete();
        src_b.delete();
        for (int i = 1; i <= 20; i++) src_a.push_back('{5'(i), 32'(i)});
        wr_count = 0;
        mon_on   = 1'b1;
        run_stream();
        mon_on = 1'b0;
        check("wrap_writes", 64'(wr_count), 64'd20);
        check("wrap_pending_idle", 64'(pending), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
